// File: rtl/serv_ibus_resp_pkg.sv
// Shared definitions for the byte-serial instruction-bus responder.
package serv_ibus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int FETCH_LAT      = 5;
    localparam int HIT_LAT        = 1;

endpackage

// File: rtl/serv_ibus_resp_lasthit.sv
// One-entry last-word buffer: tag/data/valid with compare and invalidate.
// Latency: combinational hit/data; fill and invalidate take effect next cycle.
// Backpressure: none; invalidate wins over a same-cycle fill and masks a same-cycle hit.
module serv_ibus_lasthit #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_inval,
    input  logic          i_fill,
    input  logic [TW-1:0] i_fill_tag,
    input  logic [31:0]   i_fill_dat,
    input  logic [TW-1:0] i_tag,
    output logic          o_hit,
    output logic [31:0]   o_dat
);

    logic          valid;
    logic [TW-1:0] tag;
    logic [31:0]   dat;

    always_ff @(posedge clk) begin
        if (i_rst || i_inval) begin
            valid <= 1'b0;
        end else if (i_fill) begin
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill) begin
            tag <= i_fill_tag;
            dat <= i_fill_dat;
        end
    end

    assign o_hit = valid && !i_inval && (tag == i_tag);
    assign o_dat = dat;

endmodule

// File: rtl/serv_ibus_resp.sv
// Instruction-bus responder assembling 32-bit words from byte-wide sync-read memory.
// Latency: ack 5 cycles after cyc is sampled (1 cycle on a last-word hit with SERV_IBUS_RESP_LASTHIT_EN).
// Backpressure: core holds cyc until the single-cycle ack; one fetch in flight.
module serv_ibus_resp
    import serv_ibus_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] RESET_RDT = 32'h00000013
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [31:0]       i_ibus_adr,
    input  logic              i_ibus_cyc,
    output logic [31:0]       o_ibus_rdt,
    output logic              o_ibus_ack,
    output logic [MEM_AW-1:0] o_mem_adr,
    output logic              o_mem_re,
    input  logic [7:0]        i_mem_rdata,
    input  logic              i_inval
);

    localparam int WAW = MEM_AW - 2;
    localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     cnt;
    logic [WAW-1:0] wadr;
    logic [31:0]    rdt;
    logic           hit;
    logic [31:0]    hit_dat;
    logic [WAW-1:0] req_wadr;
    logic           unused_bits;

    assign req_wadr    = i_ibus_adr[MEM_AW-1:2];
    assign unused_bits = ^{i_inval, i_ibus_adr[31:MEM_AW], i_ibus_adr[1:0]};

`ifdef SERV_IBUS_RESP_LASTHIT_EN
    serv_ibus_lasthit #(
        .TW(WAW)
    ) u_lasthit (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_inval    (i_inval),
        .i_fill     (state == ACK),
        .i_fill_tag (wadr),
        .i_fill_dat (rdt),
        .i_tag      (req_wadr),
        .o_hit      (hit),
        .o_dat      (hit_dat)
    );
`else
    assign hit     = 1'b0;
    assign hit_dat = '0;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_ibus_cyc) state_nxt = hit ? ACK : FETCH;
            FETCH:   if (cnt == LAST_BEAT) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory requests run one beat ahead of capture, so byte 0 is issued from IDLE.
    always_comb begin
        o_mem_re   = 1'b0;
        o_mem_adr  = '0;
        o_ibus_ack = 1'b0;
        if (!i_rst) begin
            case (state)
                IDLE: begin
                    if (i_ibus_cyc && !hit) begin
                        o_mem_re  = 1'b1;
                        o_mem_adr = {req_wadr, 2'b00};
                    end
                end
                FETCH: begin
                    if (cnt != LAST_BEAT) begin
                        o_mem_re  = 1'b1;
                        o_mem_adr = {wadr, cnt + 2'd1};
                    end
                end
                ACK:     o_ibus_ack = 1'b1;
                default: o_ibus_ack = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt  <= '0;
            wadr <= '0;
            rdt  <= RESET_RDT;
        end else begin
            case (state)
                IDLE: begin
                    if (i_ibus_cyc) begin
                        cnt  <= '0;
                        wadr <= req_wadr;
                        if (hit) rdt <= hit_dat;
                    end
                end
                FETCH: begin
                    rdt[{cnt, 3'b000} +: 8] <= i_mem_rdata;
                    if (cnt != LAST_BEAT) cnt <= cnt + 2'd1;
                end
                default: cnt <= cnt;
            endcase
        end
    end

    assign o_ibus_rdt = rdt;

endmodule

// File: doc/serv_ibus_resp.md
Name: serv_ibus_resp

Overview:
- Instruction-bus responder: the far end of the core's fetch interface.
- Accepts a word fetch request (address plus cyc) from the core.
- Assembles the 32-bit instruction from a byte-wide synchronous-read memory in four beats.
- Returns the word with a single-cycle ack.
- Sits between the core's ibus and a small boot RAM/ROM, for area-minimal SoCs where a 32-bit-wide memory is too costly.

Parameters:
- MEM_AW, 10, byte address width of the backing memory (1 KiB default).
- RESET_RDT, 32'h00000013, value o_ibus_rdt takes on reset (NOP).

Ports:
- clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_ibus_adr  input  32  fetch address from core; held stable while i_ibus_cyc=1
- i_ibus_cyc  input  1  fetch request; held until ack
- o_ibus_rdt  output  32  instruction word; valid when o_ibus_ack=1
- o_ibus_ack  output  1  single-cycle completion pulse
- o_mem_adr  output  MEM_AW  byte address to memory
- o_mem_re  output  1  memory read enable
- i_mem_rdata  input  8  read data; valid the cycle after o_mem_re
- i_inval  input  1  invalidate hint (e.g. memory written); used only with optional feature

Behaviour:
- Reset and interface timing:
  - One clock, clk. i_rst is synchronous, active-high.
  - Reset values: o_ibus_ack=0, o_ibus_rdt=RESET_RDT, o_mem_re=0, o_mem_adr=0, state=IDLE, beat counter=0.
- Address handling:
  - i_ibus_adr[1:0] ignored (word fetch).
  - Bits above MEM_AW-1 ignored; addresses wrap modulo 2^MEM_AW.
  - Byte k of word sits at {adr[MEM_AW-1:2], k}. Little-endian: byte k goes to rdt[8k+7:8k].
- IDLE:
  - If i_ibus_cyc=1: drive o_mem_re=1, o_mem_adr={adr[MEM_AW-1:2],2'b00}, cnt<=0, go FETCH.
  - Otherwise o_mem_re=0.
- FETCH:
  - Each cycle, capture i_mem_rdata into lane cnt.
  - While cnt<3: issue byte cnt+1 (o_mem_re=1) and increment cnt.
  - When cnt==3 has been captured: o_mem_re=0, go ACK.
  - Reads are fully pipelined: one byte issued per cycle, no bubbles.
- ACK:
  - o_ibus_ack=1 for exactly one cycle; o_ibus_rdt holds the assembled word.
  - i_ibus_cyc is ignored in this cycle, since the core drops cyc only the cycle after ack.
  - Next state always IDLE.
- Latency and throughput:
  - cyc first sampled high in cycle 0 → o_ibus_ack=1 in cycle 5.
  - Back-to-back: a new cyc may be asserted in cycle 6 and is sampled there.
- o_ibus_rdt is held between acks; it changes only as lanes are written during FETCH.
- Boundary conditions:
  - i_ibus_cyc dropping mid-FETCH is a protocol violation. The responder completes and acks anyway; the bench asserts this never happens.
  - Reset mid-FETCH or mid-ACK: IDLE on the next edge, no ack, o_mem_re=0.
  - Reset with cyc=1: no memory read in the reset cycle; fetch starts in the first cycle after reset.
  - Wrap: adr=2^MEM_AW-4 fetches the last four bytes; adr=2^MEM_AW fetches bytes 0..3.

Optional Feature:
- Macro: SERV_IBUS_RESP_LASTHIT_EN.
- With the macro: a one-entry last-word buffer (tag adr[MEM_AW-1:2], 32-bit data, valid bit).
  - Valid cleared on reset and on any cycle with i_inval=1. i_inval has priority over a same-cycle fill.
  - Filled on every ACK.
  - In IDLE with cyc=1 and a valid tag match: no memory access, go ACK directly. Ack lands in cycle 1, rdt=buffered word.
  - On a miss: normal path.
- Without the macro: i_inval ignored, every fetch takes 5 cycles, no buffer storage.

Decomposition:
- Package serv_ibus_pkg holds:
  - state encoding (IDLE=2'd0, FETCH=2'd1, ACK=2'd2);
  - BYTES_PER_WORD=4;
  - FETCH_LAT=5;
  - HIT_LAT=1.
- Sub-module serv_ibus_lasthit (tag/data/valid register, compare, invalidate) is instantiated only under the macro.
- The byte-assembly FSM stays in the top module.

Test Plan:
- Memory bytes 0x100..0x103 = 13,05,00,00; cyc with adr=0x100 → ack in cycle 5, rdt=0x00000513.
  - o_mem_adr sequence 0x100,0x101,0x102,0x103 on cycles 0..3, re=1 on each.
- Back-to-back fetches 0x000 then 0x004, second cyc raised the cycle after ack → two acks exactly 6 cycles apart, correct words, exactly one ack per request.
- adr=0x3FE with MEM_AW=10 → reads 0x3FC..0x3FF. adr=0x400 → reads 0x000..0x003.
- i_rst pulsed in cycle 2 of a fetch → no ack, o_mem_re=0 from the next cycle, rdt=0x00000013.
  - A fresh fetch then completes normally.
- Macro on: fetch 0x20 twice → second ack in cycle 1 with no o_mem_re.
  - i_inval pulse, then refetch 0x20 → 5-cycle path.
- Macro on: fetch 0x20 then 0x24 → both miss, 5 cycles each.
  - Fetch 0x24 again → hit.
  - Fetch 0x20 → miss.
